// File: rtl/perf_counter_sampler_pkg.sv
// Shared types and constants for the performance-counter sampler.
package perf_counter_sampler_pkg;

    localparam int unsigned PERF_IDX_W  = 5;
    localparam int unsigned PERF_DATA_W = 64;
    localparam int unsigned PERF_SEQ_W  = 8;

    // Counter CSR addresses; the sampler port is indexed by their low bits.
    localparam logic [11:0] CSR_ML1_ICACHE_MISS = 12'hB03;
    localparam logic [11:0] CSR_MIF_EMPTY       = 12'hB10;

    localparam logic [PERF_IDX_W-1:0] PERF_FIRST_IDX = CSR_ML1_ICACHE_MISS[PERF_IDX_W-1:0];
    localparam logic [PERF_IDX_W-1:0] PERF_LAST_IDX  = CSR_MIF_EMPTY[PERF_IDX_W-1:0];

    typedef struct packed {
        logic [PERF_IDX_W-1:0]  addr;
        logic [PERF_DATA_W-1:0] data;
        logic                   last;
        logic [PERF_SEQ_W-1:0]  seq;
    } perf_sample_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/perf_sample_fifo.sv
// Small sample FIFO with a registered head entry and registered full flag.
module perf_sample_fifo
    import perf_counter_sampler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_push,
    input  perf_sample_t i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_valid,
    output perf_sample_t o_data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    perf_sample_t             r_mem [FIFO_DEPTH];
    logic         [PTR_W-1:0] r_wr_ptr;
    logic         [PTR_W-1:0] r_rd_ptr;
    logic         [CNT_W-1:0] r_count;
    logic                     r_full;
    logic                     r_valid;
    perf_sample_t             r_head;

    logic                     w_push;
    logic                     w_pop;
    logic         [PTR_W-1:0] w_rd_ptr_next;
    logic         [CNT_W-1:0] w_count_next;
    perf_sample_t             w_head_next;

    // Full uses the current count, so a same-cycle pop never admits a push.
    always_comb begin
        w_push        = i_push && !r_full;
        w_pop         = i_pop && r_valid;
        w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
        w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
            w_head_next = i_data;
        end else begin
            w_head_next = r_mem[w_rd_ptr_next];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == CNT_W'(FIFO_DEPTH));
            r_valid  <= (w_count_next != '0);
            r_head   <= w_head_next;
        end
    end

    assign o_full  = r_full;
    assign o_valid = r_valid;
    assign o_data  = r_head;

endmodule

// File: rtl/perf_counter_sampler.sv
// Periodic sweeper of a counter index range into a tagged sample FIFO.
module perf_counter_sampler
    import perf_counter_sampler_pkg::*;
#(
    parameter logic [PERF_IDX_W-1:0] FIRST_IDX  = PERF_FIRST_IDX,
    parameter logic [PERF_IDX_W-1:0] LAST_IDX   = PERF_LAST_IDX,
    parameter int unsigned           INTERVAL   = 30000,
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   clear_on_read_i,
    input  logic                   debug_mode_i,
    output logic                   req_o,
    input  logic                   gnt_i,
    output logic [PERF_IDX_W-1:0]  addr_o,
    output logic                   we_o,
    output logic [PERF_DATA_W-1:0] wdata_o,
    input  logic [PERF_DATA_W-1:0] rdata_i,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic [PERF_IDX_W-1:0]  sample_addr_o,
    output logic [PERF_DATA_W-1:0] sample_data_o,
    output logic                   sample_last_o,
    output logic [PERF_SEQ_W-1:0]  sample_seq_o,
    output logic                   busy_o
);

    localparam int unsigned TIMER_W = $clog2(INTERVAL);

    sweep_state_e              r_state;
    logic [TIMER_W-1:0]        r_timer;
    logic [PERF_IDX_W-1:0]     r_idx;
    logic [PERF_SEQ_W-1:0]     r_seq;

    sweep_state_e              w_state_next;
    logic [TIMER_W-1:0]        w_timer_next;
    logic [PERF_IDX_W-1:0]     w_idx_next;
    logic [PERF_SEQ_W-1:0]     w_seq_next;
    logic                      w_req;
    logic                      w_we;
    logic [PERF_IDX_W-1:0]     w_addr;
    logic                      w_push;
    logic                      w_fifo_full;
    perf_sample_t              w_sample;
    perf_sample_t              w_head;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_idx   <= w_idx_next;
            r_seq   <= w_seq_next;
        end
    end

    // Timer runs only in IDLE; the sweep advances one index per granted request.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_idx_next   = r_idx;
        w_seq_next   = r_seq;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i && !debug_mode_i) begin
                    if (r_timer == TIMER_W'(INTERVAL - 1)) begin
                        w_timer_next = '0;
                        w_idx_next   = FIRST_IDX;
                        w_state_next = ST_SWEEP;
                    end else begin
                        w_timer_next = r_timer + TIMER_W'(1);
                    end
                end
            end
            ST_SWEEP: begin
                w_addr = r_idx;
                w_req  = !w_fifo_full && !debug_mode_i;
                w_we   = w_req && clear_on_read_i;
                if (w_req && gnt_i) begin
                    w_push = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_seq_next   = r_seq + PERF_SEQ_W'(1);
                        w_state_next = ST_IDLE;
                    end else begin
                        w_idx_next = r_idx + PERF_IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_sample = '{addr: r_idx, data: rdata_i, last: (r_idx == LAST_IDX), seq: r_seq};

    perf_sample_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_push (w_push),
        .i_data (w_sample),
        .i_pop  (sample_ready_i),
        .o_full (w_fifo_full),
        .o_valid(sample_valid_o),
        .o_data (w_head)
    );

    assign req_o         = w_req;
    assign we_o          = w_we;
    assign addr_o        = w_addr;
    assign wdata_o       = '0;
    assign busy_o        = (r_state == ST_SWEEP);
    assign sample_addr_o = w_head.addr;
    assign sample_data_o = w_head.data;
    assign sample_last_o = w_head.last;
    assign sample_seq_o  = w_head.seq;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Bench for perf_counter_sampler: cycle table for sweep start/stall plus a sample scoreboard.
module tb_perf_counter_sampler;
    import perf_counter_sampler_pkg::*;

    localparam int unsigned INTERVAL = 8;
    localparam int unsigned DEPTH    = 4;
    localparam logic [4:0]  FIRST    = 5'd3;
    localparam logic [4:0]  LAST     = 5'd16;

    logic        clk;
    logic        rst_ni;
    logic        enable_i;
    logic        clear_on_read_i;
    logic        debug_mode_i;
    logic        req_o;
    logic        gnt_i;
    logic [4:0]  addr_o;
    logic        we_o;
    logic [63:0] wdata_o;
    logic [63:0] rdata_i;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic [4:0]  sample_addr_o;
    logic [63:0] sample_data_o;
    logic        sample_last_o;
    logic [7:0]  sample_seq_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    perf_counter_sampler #(
        .FIRST_IDX (FIRST),
        .LAST_IDX  (LAST),
        .INTERVAL  (INTERVAL),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .clear_on_read_i(clear_on_read_i),
        .debug_mode_i   (debug_mode_i),
        .req_o          (req_o),
        .gnt_i          (gnt_i),
        .addr_o         (addr_o),
        .we_o           (we_o),
        .wdata_o        (wdata_o),
        .rdata_i        (rdata_i),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_addr_o  (sample_addr_o),
        .sample_data_o  (sample_data_o),
        .sample_last_o  (sample_last_o),
        .sample_seq_o   (sample_seq_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter memory: read-before-write port, reloadable with a linear pattern.
    logic [63:0] mem [32];
    logic        reload;
    int unsigned rl_mul;
    int unsigned rl_add;

    always @(posedge clk) begin
        if (reload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 64'(i * rl_mul + rl_add);
        end else if (req_o && gnt_i && we_o) begin
            mem[addr_o] <= wdata_o;
        end
    end
    assign rdata_i = mem[addr_o];

    perf_sample_t exp_q[$];

    // Sample consumer: compare each handshake against the expected sample order.
    always @(negedge clk) begin
        if (rst_ni && sample_valid_o && sample_ready_i) begin
            perf_sample_t got;
            perf_sample_t exp;
            got = '{addr: sample_addr_o, data: sample_data_o, last: sample_last_o, seq: sample_seq_o};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sample_extra got addr=%0d data=%0d last=%0b seq=%0d required none",
                         got.addr, got.data, got.last, got.seq);
            end else begin
                exp = exp_q.pop_front();
                if (got != exp) begin
                    failures++;
                    $display("FAIL sample got addr=%0d data=%0d last=%0b seq=%0d required addr=%0d data=%0d last=%0b seq=%0d",
                             got.addr, got.data, got.last, got.seq, exp.addr, exp.data, exp.last, exp.seq);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h required=0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input logic [7:0] s);
        for (int i = int'(FIRST); i <= int'(LAST); i++) begin
            exp_q.push_back('{addr: 5'(i), data: mem[i], last: (5'(i) == LAST), seq: s});
        end
    endtask

    task automatic wait_busy(input logic level, input int budget, output int n);
        n = 0;
        while (busy_o !== level && n < budget) begin
            step();
            n++;
        end
        if (busy_o !== level) chk("busy_timeout", 64'(busy_o), 64'(level));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic       en;
        logic       gnt;
        logic       dbg;
        logic       exp_busy;
        logic       exp_req;
        logic [4:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(logic en, logic g, logic d, logic b, logic r, logic [4:0] a);
        vec_t v;
        v = '{en: en, gnt: g, dbg: d, exp_busy: b, exp_req: r, exp_addr: a};
        return v;
    endfunction

    initial begin
        vec_t vecs[24];
        int   n;
        int   granted;
        int   bad;

        // Interval with a 5-cycle debug freeze, sweep start, mid-sweep freeze, a denied grant.
        for (int i = 0; i < 2; i++)   vecs[i] = mk(1, 1, 0, 0, 0, 5'd0);
        for (int i = 2; i < 7; i++)   vecs[i] = mk(1, 1, 1, 0, 0, 5'd0);
        for (int i = 7; i < 13; i++)  vecs[i] = mk(1, 1, 0, 0, 0, 5'd0);
        vecs[13] = mk(1, 1, 0, 1, 1, 5'd3);
        vecs[14] = mk(1, 1, 0, 1, 1, 5'd4);
        for (int i = 15; i < 20; i++) vecs[i] = mk(1, 1, 1, 1, 0, 5'd5);
        vecs[20] = mk(1, 1, 0, 1, 1, 5'd5);
        vecs[21] = mk(1, 0, 0, 1, 1, 5'd6);
        vecs[22] = mk(1, 1, 0, 1, 1, 5'd6);
        vecs[23] = mk(1, 1, 0, 1, 1, 5'd7);

        rst_ni          = 1'b0;
        enable_i        = 1'b0;
        clear_on_read_i = 1'b0;
        debug_mode_i    = 1'b0;
        gnt_i           = 1'b1;
        sample_ready_i  = 1'b1;
        reload          = 1'b1;
        rl_mul          = 10;
        rl_add          = 0;
        step();
        step();
        reload = 1'b0;
        chk("reset_ctrl", 64'({req_o, we_o, addr_o, busy_o, sample_valid_o, sample_last_o,
                               sample_addr_o, sample_seq_o}), 64'd0);
        chk("reset_wdata", wdata_o, 64'd0);
        chk("reset_sample_data", sample_data_o, 64'd0);

        rst_ni = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("disabled_idle", 64'(busy_o), 64'd0);

        push_sweep(8'd0);
        for (int i = 0; i < 24; i++) begin
            enable_i     = vecs[i].en;
            gnt_i        = vecs[i].gnt;
            debug_mode_i = vecs[i].dbg;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 64'({busy_o, req_o, addr_o}),
                64'({vecs[i].exp_busy, vecs[i].exp_req, vecs[i].exp_addr}));
            step();
        end
        gnt_i        = 1'b1;
        debug_mode_i = 1'b0;
        wait_busy(1'b0, 40, n);
        drain("sweep0_drain");

        // Clear-on-read sweep, seq 1: pre-clear values read, zero written each grant.
        clear_on_read_i = 1'b1;
        push_sweep(8'd1);
        wait_busy(1'b1, 20, n);
        granted = 0;
        bad     = 0;
        n       = 0;
        while (busy_o && n < 60) begin
            if (req_o && gnt_i) begin
                granted++;
                if (!we_o || wdata_o != 64'd0) bad++;
            end
            step();
            n++;
        end
        clear_on_read_i = 1'b0;
        chk("clear_grants", 64'(granted), 64'd14);
        chk("clear_write_errors", 64'(bad), 64'd0);
        drain("sweep1_drain");

        // Alternating grant, seq 2, counters now zero.
        push_sweep(8'd2);
        wait_busy(1'b1, 20, n);
        gnt_i = 1'b0;
        n     = 0;
        while (busy_o && n < 80) begin
            step();
            n++;
            gnt_i = ~gnt_i;
        end
        gnt_i = 1'b1;
        chk("toggle_sweep_cycles", 64'(n), 64'd28);
        drain("sweep2_drain");

        // Backpressure, seq 3: four samples then stall at index 7.
        reload = 1'b1;
        rl_mul = 7;
        rl_add = 1;
        step();
        reload         = 1'b0;
        sample_ready_i = 1'b0;
        push_sweep(8'd3);
        wait_busy(1'b1, 20, n);
        for (int i = 0; i < 10; i++) step();
        chk("backpressure_hold", 64'({busy_o, req_o, sample_valid_o, addr_o}),
            64'({1'b1, 1'b0, 1'b1, 5'd7}));
        sample_ready_i = 1'b1;
        wait_busy(1'b0, 60, n);
        drain("sweep3_drain");

        // Reset at index 9 with two samples queued.
        push_sweep(8'd4);
        wait_busy(1'b1, 20, n);
        n = 0;
        while (addr_o != 5'd8 && n < 30) begin
            step();
            n++;
        end
        sample_ready_i = 1'b0;
        step();
        chk("reset_setup", 64'({addr_o, sample_valid_o}), 64'({5'd9, 1'b1}));
        rst_ni = 1'b0;
        step();
        chk("midreset_ctrl", 64'({req_o, we_o, addr_o, busy_o, sample_valid_o, sample_last_o,
                                  sample_addr_o, sample_seq_o}), 64'd0);
        chk("midreset_sample_data", sample_data_o, 64'd0);
        rst_ni = 1'b1;
        exp_q.delete();
        push_sweep(8'd0);
        sample_ready_i = 1'b1;
        wait_busy(1'b1, 30, n);
        chk("post_reset_start", 64'(n), 64'(INTERVAL));
        wait_busy(1'b0, 40, n);
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog got=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/perf_counter_sampler.md
# perf_counter_sampler

Autonomous initiator on the performance-counter SRAM-like port. When enabled, it sweeps a fixed index range of counters after every programmable idle interval. Each counter's value goes into a small FIFO as a tagged sample, with optional atomic clear-on-read. The block sits beside the CSR file, behind a 2:1 port mux that grants it access when the CSR file is not accessing counters. Its sample stream feeds trace/debug logic.

## Interface
- FIRST_IDX, 5'd3: first counter index swept (low 5 address bits).
- LAST_IDX, 5'd16: last counter index swept; must be ≥ FIRST_IDX.
- INTERVAL, 30000: idle cycles between sweeps (≥ 2).
- FIFO_DEPTH, 4: sample FIFO entries (power of two).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- enable_i  in  1  start/continue periodic sweeping.
- clear_on_read_i  in  1  zero each counter in the same cycle it is read.
- debug_mode_i  in  1  freeze timer and stall sweep.
- req_o  out  1  request counter port this cycle.
- gnt_i  in  1  port granted (combinational from mux).
- addr_o  out  5  counter index.
- we_o  out  1  write enable (clear).
- wdata_o  out  64  write data, always 0.
- rdata_i  in  64  counter value, combinational on addr_o, pre-write value.
- sample_valid_o  out  1  sample available.
- sample_ready_i  in  1  consumer accepts sample.
- sample_addr_o  out  5  counter index of sample.
- sample_data_o  out  64  counter value.
- sample_last_o  out  1  sample is LAST_IDX of its sweep.
- sample_seq_o  out  8  sweep sequence number.
- busy_o  out  1  FSM in SWEEP.

## Operation
- FSM states:
  - IDLE: the interval timer counts.
  - SWEEP: counters are read one per granted cycle.
- IDLE:
  - timer increments when enable_i && !debug_mode_i, and holds otherwise.
  - When timer == INTERVAL-1 and the increment condition holds: timer←0, idx←FIRST_IDX, next state SWEEP.
- SWEEP:
  - req_o = !fifo_full && !debug_mode_i.
  - addr_o = idx.
  - we_o = req_o && clear_on_read_i.
  - On req_o && gnt_i: push {idx, rdata_i, idx==LAST_IDX, seq} into the FIFO.
  - If idx == LAST_IDX: seq←seq+1 (8-bit wrap 255→0), then IDLE. Otherwise idx←idx+1.
  - No gnt_i: hold idx, no push, retry next cycle.
- Clear is atomic with read, because the port is write-after-read in one cycle. Increments landing in that exact cycle are lost; this is accepted.
- enable_i deasserted mid-sweep: the sweep completes and the FSM returns to IDLE. The timer then stays at 0 until re-enabled.
- FIFO:
  - push only when not full; full is evaluated on the current count, so simultaneous pop does not free a slot the same cycle.
  - pop on sample_valid_o && sample_ready_i.
  - Simultaneous push and pop keeps count.
- Outputs are inactive in IDLE: req_o, we_o, addr_o=0.

## Timing
- Reset values:
  - state IDLE, timer 0, idx 0, seq 0, FIFO empty.
  - All outputs 0: req_o, we_o, addr_o, wdata_o, sample_* , busy_o.
- The first sweep starts INTERVAL cycles after enable_i rises. busy_o is high on cycle INTERVAL (enable at cycle 0).
- Sweep length with gnt_i=1 and no backpressure: N = LAST_IDX-FIRST_IDX+1 cycles. Counters 3..16 take 14 cycles.
- Push at cycle t gives sample_valid_o at t+1. FIFO outputs are registered and show the head entry.
- Backpressure: a full FIFO drops req_o in the same cycle. The sweep resumes the cycle after a pop frees a slot.
- Reset mid-sweep: next cycle is the reset state and the FIFO is flushed. No partial write is generated after reset.

## Structure
- ariane_pkg gets:
  - typedef perf_sample_t {logic [4:0] addr; logic [63:0] data; logic last; logic [7:0] seq;}.
  - localparams PERF_FIRST_IDX and PERF_LAST_IDX derived from the riscv CSR_ML1_ICACHE_MISS / CSR_MIF_EMPTY offsets.
- Sub-module perf_sample_fifo (parameterised FIFO_DEPTH, data type perf_sample_t):
  - registered output, full/empty, synchronous active-low reset.
- Top-level holds the FSM, the timer (width $clog2(INTERVAL)), idx and seq.

## Test plan
- INTERVAL=8, gnt_i=1, sample_ready_i=1, rdata_i=idx*10, enable at cycle 0:
  - busy_o rises at cycle 8.
  - 14 samples addr 3..16, data 30..160, seq 0.
  - last only on addr 16.
  - Next sweep has seq 1.
- clear_on_read_i=1: we_o=1 and wdata_o=0 on every granted cycle. A model counter reads its pre-clear value, then 0 on the next sweep.
- gnt_i toggling 1,0,1,0: each index is read exactly once, with no duplicates or skips. The sweep takes 28 cycles.
- sample_ready_i=0, FIFO_DEPTH=4:
  - 4 samples pushed, then req_o=0 with idx held at 7.
  - Ready raised: the sweep resumes, and all 14 samples arrive in order.
- debug_mode_i pulsed 5 cycles in IDLE and mid-sweep: the timer and idx freeze 5 cycles with req_o=0, then the sweep resumes.
- rst_ni low for one cycle at idx 9 with 2 samples queued:
  - All outputs 0 next cycle, FIFO empty.
  - Next sweep starts INTERVAL cycles after reset release with seq 0.
